// File: rtl/rx_unpacket_router.sv
// Drains one received packet from the RX BRAM and routes its words to a per-type
// output channel, optionally packing two words per write and counting finished packets.
module rx_unpacket_router #(
   parameter int                 DATA_W    = 32,
   parameter int                 ADDR_W    = 11,
   parameter int                 NUM_CH    = 4,
   parameter logic [63:0]        TYPE_MAP  = '0,
   parameter logic [NUM_CH-1:0]  PACK_MASK = '0,
   parameter logic [15:0]        HDR_MASK  = '0,
   parameter logic [NUM_CH-1:0]  CNT_MASK  = '0,
   parameter logic [31:0]        CNT_LIMIT = 32'd96
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       msg_accessed,
   input  logic                       busy_Net2PP_RX,
   output logic                       busy_PP2Net_RX,
   output logic [ADDR_W-1:0]          bram_addrb,
   input  logic [DATA_W-1:0]          bram_doutb,
   output logic [NUM_CH-1:0]          ch_wr_en,
   output logic [NUM_CH*2*DATA_W-1:0] ch_wr_din,
   input  logic [NUM_CH-1:0]          ch_full,
   input  logic                       cnt_clr,
   output logic                       cnt_full,
   output logic                       err_pkt,
   output logic [2:0]                 state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0, HDR_RD = 3'd1, HDR_WAIT = 3'd2, PARSE = 3'd3,
      STREAM = 3'd4, FLUSH = 3'd5, DONE = 3'd6, WAIT_REL = 3'd7
   } state_t;

   localparam int LW = 11;
   localparam logic [LW-1:0] L_ONE = LW'(1);

   state_t            state_q;
   logic              busy_q, err_q, bad_q;
   logic [DATA_W-1:0] hdr_q;
   logic [2:0]        ch_q;
   logic              pack_q;
   logic [LW-1:0]     depth_q, iss_q, rem_q;
   logic [ADDR_W-1:0] addr_q;
   logic              iss_vld_q, dat_vld_q;
   logic [DATA_W-1:0] sk0_q, sk1_q, half_q;
   logic [1:0]        sk_cnt_q;
   logic              half_vld_q;
   logic [31:0]       cnt_q;

   logic [3:0]          hdr_type, len_code, map_e;
   logic [LW-1:0]       dec_depth;
   logic                len_ok, dec_ok, dec_fwd;
   logic [7:0]          full_pad, pack_pad, cntm_pad;
   logic                sel_full, pop, push, wr, issue;
   logic [DATA_W-1:0]   push_data;
   logic [2*DATA_W-1:0] wr_data;
   logic [1:0]          sk_after;
   logic [2:0]          outstanding;

   always_comb begin
      hdr_type  = hdr_q[31:28];
      len_code  = hdr_q[27:24];
      map_e     = TYPE_MAP[{hdr_type, 2'b00} +: 4];
      dec_depth = '0;
      len_ok    = 1'b1;
      case (len_code)
         4'd1:    dec_depth = LW'(hdr_q[23:15]);
         4'd2:    dec_depth = LW'(512);
         4'd3:    dec_depth = LW'(768);
         4'd4:    dec_depth = LW'(1024);
         default: len_ok = 1'b0;
      endcase
      dec_ok  = map_e[3] && (int'(map_e[2:0]) < NUM_CH) && len_ok;
      dec_fwd = HDR_MASK[hdr_type];
   end

   always_comb begin
      full_pad = '0;
      pack_pad = '0;
      cntm_pad = '0;
      full_pad[NUM_CH-1:0] = ch_full;
      pack_pad[NUM_CH-1:0] = PACK_MASK;
      cntm_pad[NUM_CH-1:0] = CNT_MASK;
      sel_full = full_pad[ch_q];
   end

   // The skid buffer head feeds the channel; a packed first half moves into half_q without a write.
   always_comb begin
      pop     = 1'b0;
      wr      = 1'b0;
      wr_data = '0;
      if (state_q == STREAM && sk_cnt_q != 2'd0) begin
         if (pack_q && !half_vld_q) begin
            pop = 1'b1;
         end else if (!sel_full) begin
            pop     = 1'b1;
            wr      = 1'b1;
            wr_data = pack_q ? {half_q, sk0_q} : {{DATA_W{1'b0}}, sk0_q};
         end
      end else if (state_q == FLUSH && half_vld_q && !sel_full) begin
         wr      = 1'b1;
         wr_data = {half_q, {DATA_W{1'b0}}};
      end
      push        = dat_vld_q || (state_q == PARSE && dec_ok && dec_fwd);
      push_data   = dat_vld_q ? bram_doutb : hdr_q;
      sk_after    = sk_cnt_q - {1'b0, pop};
      // Words already buffered plus reads in flight may never exceed the two skid slots.
      outstanding = {1'b0, sk_after} + {2'b0, iss_vld_q} + {2'b0, dat_vld_q};
      issue       = (state_q == STREAM) && (iss_q < depth_q) && !sel_full && (outstanding < 3'd2);
   end

   always_comb begin
      ch_wr_en  = '0;
      ch_wr_din = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr && rst_n && int'(ch_q) == c) begin
            ch_wr_en[c] = 1'b1;
            ch_wr_din[c*2*DATA_W +: 2*DATA_W] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         bad_q      <= 1'b0;
         hdr_q      <= '0;
         ch_q       <= '0;
         pack_q     <= 1'b0;
         depth_q    <= '0;
         iss_q      <= '0;
         rem_q      <= '0;
         addr_q     <= '0;
         iss_vld_q  <= 1'b0;
         dat_vld_q  <= 1'b0;
         sk0_q      <= '0;
         sk1_q      <= '0;
         sk_cnt_q   <= '0;
         half_q     <= '0;
         half_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         err_q     <= 1'b0;
         iss_vld_q <= issue;
         dat_vld_q <= iss_vld_q;
         addr_q    <= issue ? ADDR_W'(iss_q + L_ONE) : '0;
         if (issue) iss_q <= iss_q + L_ONE;
         if (pop) rem_q <= rem_q - L_ONE;
         if (pop) sk0_q <= sk1_q;
         if (push) begin
            if (sk_after == 2'd0) sk0_q <= push_data;
            else                  sk1_q <= push_data;
         end
         sk_cnt_q <= sk_after + {1'b0, push};
         if (pop && pack_q && !half_vld_q) begin
            half_q     <= sk0_q;
            half_vld_q <= 1'b1;
         end else if (wr && pack_q) begin
            half_vld_q <= 1'b0;
         end
         if (cnt_clr) cnt_q <= '0;
         else if (state_q == DONE && !bad_q && cntm_pad[ch_q] && cnt_q < CNT_LIMIT) cnt_q <= cnt_q + 32'd1;
         case (state_q)
            IDLE: if (msg_accessed && !busy_Net2PP_RX) begin
               state_q <= HDR_RD;
               busy_q  <= 1'b1;
            end
            HDR_RD:   state_q <= HDR_WAIT;
            HDR_WAIT: begin
               hdr_q   <= bram_doutb;
               state_q <= PARSE;
            end
            PARSE: begin
               ch_q    <= map_e[2:0];
               pack_q  <= pack_pad[map_e[2:0]];
               depth_q <= dec_depth;
               iss_q   <= '0;
               rem_q   <= dec_depth + LW'(dec_fwd);
               bad_q   <= !dec_ok;
               if (dec_ok) begin
                  state_q <= STREAM;
               end else begin
                  err_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            STREAM: if (rem_q == '0) state_q <= FLUSH;
            FLUSH:  if (!half_vld_q || !sel_full) state_q <= DONE;
            DONE:   state_q <= WAIT_REL;
            WAIT_REL: if (!msg_accessed) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_PP2Net_RX = busy_q;
   assign bram_addrb     = addr_q;
   assign err_pkt        = err_q;
   assign cnt_full       = (cnt_q == CNT_LIMIT);
   assign state          = state_q;

endmodule

// File: doc/rx_unpacket_router.md
RX_UNPACKET_ROUTER -- requirements
Module: rx_unpacket_router

Interface
REQ-001 SHALL have parameter DATA_W, default 32: BRAM word width.
REQ-002 SHALL have parameter ADDR_W, default 11: BRAM address width.
REQ-003 SHALL have parameter NUM_CH, default 4 (range 1..8): number of output channels.
REQ-004 SHALL have parameter TYPE_MAP, 16x4 bits, default 0: per packet type; bit3 = type valid, bits2:0 = channel.
REQ-005 SHALL have parameter PACK_MASK, NUM_CH bits, default 0: a set bit packs two words per write on that channel.
REQ-006 SHALL have parameter HDR_MASK, 16 bits, default 0: a set bit forwards the header word for that type.
REQ-007 SHALL have parameter CNT_MASK, NUM_CH bits, and CNT_LIMIT, 32 bits, defaults 0 and 96: completed-packet counter scope and threshold.
REQ-008 SHALL have the ports: clk in 1, clock; rst_n in 1, reset, synchronous, active-low.
REQ-009 SHALL have the ports: msg_accessed in 1, packet present in BRAM; busy_Net2PP_RX in 1, network still writing.
REQ-010 SHALL have the port busy_PP2Net_RX out 1: asserted while the block owns the BRAM.
REQ-011 SHALL have the ports: bram_addrb out ADDR_W; bram_doutb in DATA_W, valid one clk after the address.
REQ-012 SHALL have the ports: ch_wr_en out NUM_CH; ch_wr_din out NUM_CH*2*DATA_W, with channel c at slice c; ch_full in NUM_CH.
REQ-013 SHALL have the ports: cnt_clr in 1; cnt_full out 1; err_pkt out 1 (one-cycle pulse); state out 3.

Function
REQ-014 SHALL decode header word (address 0): type = [31:28]; len code = [27:24].
REQ-015 SHALL map the len code to payload depth: 1 -> [23:15] (0 = empty payload); 2 -> 512; 3 -> 768; 4 -> 1024; any other code is an error.
REQ-016 SHALL read the payload from addresses 1..depth, in ascending order.
REQ-017 SHALL use the FSM states IDLE=0, HDR_RD=1, HDR_WAIT=2, PARSE=3, STREAM=4, FLUSH=5, DONE=6, WAIT_REL=7.
REQ-018 SHALL take IDLE -> HDR_RD when msg_accessed=1 and busy_Net2PP_RX=0; otherwise it stays in IDLE.
REQ-019 SHALL take HDR_RD -> HDR_WAIT -> PARSE unconditionally; the header is registered in PARSE.
REQ-020 SHALL take PARSE -> STREAM when the type is valid and the len code is legal; otherwise it pulses err_pkt, writes nothing, and goes to DONE.
REQ-021 SHALL take STREAM -> FLUSH once all words have been accepted; FLUSH -> DONE after any pending half-word is written.
REQ-022 SHALL take DONE -> WAIT_REL after one cycle; WAIT_REL -> IDLE when msg_accessed=0.
REQ-023 SHALL drive busy_PP2Net_RX=1 in every state except IDLE.
REQ-024 SHALL, when HDR_MASK[type]=1, emit the header word as the first word of the stream.
REQ-025 SHALL, on an unpacked channel, put each word in ch_wr_din[c] low DATA_W bits with the high bits zero, and pulse ch_wr_en[c] for one cycle per word.
REQ-026 SHALL, on a packed channel, emit {first, second} as one write; an odd final word is emitted in FLUSH as {last, zero}.
REQ-027 SHALL, for backpressure, issue no write while ch_full[c]=1.
REQ-028 SHALL stop issuing addresses while ch_full[c]=1, using a 2-entry skid buffer so in-flight read data is held.
REQ-029 SHALL never lose, duplicate or reorder a word, for any ch_full pattern.
REQ-030 SHALL keep all non-selected channel enables at 0 and their data at 0.
REQ-031 SHALL drive bram_addrb to 0 when it is not reading.
REQ-032 SHALL increment the packet counter in DONE for packets that finished without error on a channel in CNT_MASK.
REQ-033 SHALL hold cnt_full = (counter == CNT_LIMIT); the counter saturates at CNT_LIMIT.
REQ-034 SHALL give cnt_clr priority over an increment in the same cycle, clearing the counter to 0.
REQ-035 SHALL ignore msg_accessed in every state except IDLE and WAIT_REL.

Reset
REQ-036 SHALL, on rst_n=0 at a clk edge, set: state=IDLE, busy_PP2Net_RX=0, all ch_wr_en=0, ch_wr_din=0, bram_addrb=0, err_pkt=0, cnt_full=0.
REQ-037 SHALL also clear the counter, the skid buffer, the pack half-register and the header register on reset.
REQ-038 SHALL abort any packet in progress on a reset mid-packet; no further writes follow.

Verification
REQ-039 Unpacked ch0, header 0x1_1_0A0000 (len 20), TYPE_MAP[1]=8 -> 20 ch_wr_en[0] pulses, data equals BRAM[1..20], then DONE and WAIT_REL.
REQ-040 Packed ch1, len 5, HDR_MASK set -> 3 writes: {hdr,w1}, {w2,w3}, {w4,w5}.
REQ-041 Packed, len 3, no header -> writes {w1,w2}, then {w3,0} in FLUSH.
REQ-042 Len code 4, random ch_full toggling -> exactly 1024 writes, in order, with no write while full.
REQ-043 Len code 7 or invalid type -> err_pkt pulse, zero writes, counter unchanged, busy released after msg_accessed=0.
REQ-044 CNT_LIMIT=2: three valid packets -> cnt_full=1 after the second, counter holds; cnt_clr -> counter=0; reset in STREAM -> IDLE next cycle.
